memory_access: RTL and testbench

//  Pipeline MEM stage: consumes the EX/MEM register produced by the execute stage.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/load_store_align.sv | 44 ++++
 rtl/memory_access.sv | 188 ++++++++++++++++++
 tb/tb_memory_access.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - MEM-stage types, control-word bit positions and alignment helper
package mem_pkg;

  typedef enum logic [1:0] {MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10} mem_size_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10} wb_sel_e;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  localparam int CTRL_MEM_READ  = 13;
  localparam int CTRL_MEM_WRITE = 12;
  localparam int CTRL_SIZE_HI   = 11;
  localparam int CTRL_SIZE_LO   = 10;
  localparam int CTRL_LOAD_UNS  = 9;
  localparam int CTRL_WB_HI     = 8;
  localparam int CTRL_WB_LO     = 7;

  // Size encoding 2'b11 is not defined; it is checked like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic w_mis;
    case (mem_size_e'(size))
      MEM_B:   w_mis = 1'b0;
      MEM_H:   w_mis = addr_lo[0];
      default: w_mis = (addr_lo != 2'b00);
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - store lane replication/byte enables and load lane extract/extend
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_load_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_raw,
  output logic [31:0] o_store_data,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_load_raw[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_load_raw[31:16] : i_load_raw[15:0];

  always_comb begin
    o_store_data = i_store_data;
    o_byte_en    = 4'b1111;
    o_load_data  = i_load_raw;
    case (mem_size_e'(i_size))
      MEM_B: begin
        o_store_data = {4{i_store_data[7:0]}};
        o_byte_en    = 4'b0001 << i_addr_lo;
        o_load_data  = i_load_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      MEM_H: begin
        o_store_data = {2{i_store_data[15:0]}};
        o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_load_data  = i_load_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_store_data = i_store_data;
        o_byte_en    = 4'b1111;
        o_load_data  = i_load_raw;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - pipeline MEM stage: data-memory port, stall control, MEM/WB register
module memory_access
  import mem_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter int CTRL_SIZE = 21,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int REG_BITS = $clog2(REG_COUNT),
  localparam int CTRL_W   = CTRL_SIZE - 7,
  localparam int IN_W     = REG_BITS + 1 + CTRL_W + 3 * REG_WIDTH,
  localparam int OUT_W    = REG_BITS + 1 + REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      exc_mem_reg,
  output logic [OUT_W-1:0]     mem_wb_reg,
  output logic                 stall,
  output logic                 misaligned,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [31:0]          dmem_addr,
  output logic [31:0]          dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ready,
`ifdef MEM_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  input  logic [31:0]          dmem_rdata
);

  state_e              r_state, w_next_state;
  logic [IN_W-1:0]     r_hold;
  logic [OUT_W-1:0]    r_mem_wb;
  logic                r_misaligned;

  logic [IN_W-1:0]     w_cur;
  assign w_cur = (r_state == WAIT) ? r_hold : exc_mem_reg;

  logic [REG_WIDTH-1:0] w_return_pc, w_rs2, w_alu_out;
  logic [CTRL_W-1:0]    w_ctrl;
  logic                 w_write_en;
  logic [REG_BITS-1:0]  w_rd;

  assign w_return_pc = w_cur[REG_WIDTH-1:0];
  assign w_rs2       = w_cur[2*REG_WIDTH-1:REG_WIDTH];
  assign w_alu_out   = w_cur[3*REG_WIDTH-1:2*REG_WIDTH];
  assign w_ctrl      = w_cur[3*REG_WIDTH+CTRL_W-1:3*REG_WIDTH];
  assign w_write_en  = w_cur[3*REG_WIDTH+CTRL_W];
  assign w_rd        = w_cur[IN_W-1 -: REG_BITS];

  logic       w_mem_read, w_mem_write, w_mem_op, w_load_uns, w_misal;
  logic [1:0] w_size;
  wb_sel_e    w_wb_sel;

  assign w_mem_read  = w_ctrl[CTRL_MEM_READ];
  assign w_mem_write = w_ctrl[CTRL_MEM_WRITE];
  assign w_mem_op    = w_mem_read | w_mem_write;
  assign w_size      = w_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO];
  assign w_load_uns  = w_ctrl[CTRL_LOAD_UNS];
  assign w_wb_sel    = wb_sel_e'(w_ctrl[CTRL_WB_HI:CTRL_WB_LO]);
  assign w_misal     = w_mem_op & is_misaligned(w_size, w_alu_out[1:0]);

  logic w_unused;
  assign w_unused = &{1'b0, w_ctrl[CTRL_WB_LO-1:0]};

  logic [31:0] w_store_data, w_load_data;
  logic [3:0]  w_byte_en;

  load_store_align u_align (
    .i_size          (w_size),
    .i_load_unsigned (w_load_uns),
    .i_addr_lo       (w_alu_out[1:0]),
    .i_store_data    (w_rs2),
    .i_load_raw      (dmem_rdata),
    .o_store_data    (w_store_data),
    .o_byte_en       (w_byte_en),
    .o_load_data     (w_load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;
`endif

  logic w_req, w_stall, w_abort, w_misal_pulse;

  always_comb begin
    w_next_state  = r_state;
    w_req         = 1'b0;
    w_stall       = 1'b0;
    w_abort       = 1'b0;
    w_misal_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_misal) begin
            w_misal_pulse = 1'b1;
          end else begin
            w_req = 1'b1;
            if (!dmem_ready) begin
              w_stall      = 1'b1;
              w_next_state = WAIT;
            end
          end
        end
      end
      WAIT: begin
        w_req = 1'b1;
        if (dmem_ready) begin
          w_next_state = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end
`endif
        else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  logic [REG_WIDTH-1:0] w_wb_data;
  logic [OUT_W-1:0]     w_mem_wb_next;

  always_comb begin
    w_wb_data = w_alu_out;
    if (!w_mem_write) begin
      case (w_wb_sel)
        WB_MEM:  w_wb_data = w_load_data;
        WB_PC:   w_wb_data = w_return_pc;
        default: w_wb_data = w_alu_out;
      endcase
    end
  end

  always_comb begin
    w_mem_wb_next = {w_rd, w_write_en, w_wb_data};
    if (w_stall || w_abort || w_misal_pulse) begin
      w_mem_wb_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_mem_wb     <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_mem_wb     <= w_mem_wb_next;
      r_misaligned <= w_misal_pulse;
      if (r_state == IDLE) begin
        r_hold <= exc_mem_reg;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt    <= (w_next_state == WAIT && r_state == WAIT) ? r_wait_cnt + 1'b1 : '0;
      r_timeout_err <= r_timeout_err | w_abort;
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  assign mem_wb_reg = r_mem_wb;
  assign misaligned = r_misaligned;
  assign stall      = w_stall;
  assign dmem_req   = w_req;
  assign dmem_we    = w_req & w_mem_write;
  assign dmem_addr  = {w_alu_out[31:2], 2'b00};
  assign dmem_wdata = w_store_data;
  assign dmem_be    = w_req ? w_byte_en : 4'b0000;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

  logic         clk = 1'b0;
  logic         rst;
  logic [115:0] exc_mem_reg;
  logic [37:0]  mem_wb_reg;
  logic         stall, misaligned, dmem_req, dmem_we, dmem_ready;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_be;
`ifdef MEM_TIMEOUT_EN
  logic         timeout_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .exc_mem_reg (exc_mem_reg),
    .mem_wb_reg  (mem_wb_reg),
    .stall       (stall),
    .misaligned  (misaligned),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ready  (dmem_ready),
`ifdef MEM_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .dmem_rdata  (dmem_rdata)
  );

  function automatic logic [13:0] ctl(input logic mr, input logic mw, input logic [1:0] sz,
                                      input logic uns, input logic [1:0] wb);
    return {mr, mw, sz, uns, wb, 7'b0};
  endfunction

  function automatic logic [115:0] pk(input logic [4:0] rd, input logic we, input logic [13:0] c,
                                      input logic [31:0] alu, input logic [31:0] rs2,
                                      input logic [31:0] pc);
    return {rd, we, c, alu, rs2, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [115:0] e, input logic rdy, input logic [31:0] rdat);
    @(negedge clk);
    exc_mem_reg = e;
    dmem_ready  = rdy;
    dmem_rdata  = rdat;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [115:0] e, input logic [31:0] rdat,
                         input int waits, input logic [31:0] exp_addr, input logic [37:0] exp_wb);
    for (int i = 0; i < waits; i++) begin
      drive(e, 1'b0, rdat);
      chk({tag, " stall"}, 64'(stall), 64'd1);
      chk({tag, " req"}, 64'(dmem_req), 64'd1);
      tick;
      chk({tag, " bubble"}, 64'(mem_wb_reg), 64'd0);
    end
    drive(e, 1'b1, rdat);
    chk({tag, " stall_done"}, 64'(stall), 64'd0);
    chk({tag, " we"}, 64'(dmem_we), 64'd0);
    chk({tag, " addr"}, 64'(dmem_addr), 64'(exp_addr));
    tick;
    chk({tag, " wb"}, 64'(mem_wb_reg), 64'(exp_wb));
  endtask

  initial begin
    rst         = 1'b1;
    exc_mem_reg = '0;
    dmem_ready  = 1'b0;
    dmem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_wb", 64'(mem_wb_reg), 64'd0);
    chk("rst misaligned", 64'(misaligned), 64'd0);
    chk("rst req", 64'(dmem_req), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
`ifdef MEM_TIMEOUT_EN
    chk("rst timeout_err", 64'(timeout_err), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    drive(pk(5'd5, 1'b1, ctl(0, 0, 2'b10, 0, 2'b00), 32'h1234, 32'h0, 32'h0), 1'b0, 32'h0);
    chk("alu req", 64'(dmem_req), 64'd0);
    chk("alu stall", 64'(stall), 64'd0);
    tick;
    chk("alu wb", 64'(mem_wb_reg), 64'({5'd5, 1'b1, 32'h1234}));

    drive(pk(5'd0, 1'b0, ctl(0, 1, 2'b10, 0, 2'b00), 32'h100, 32'hDEADBEEF, 32'h0), 1'b1, 32'h0);
    chk("sw req", 64'(dmem_req), 64'd1);
    chk("sw we", 64'(dmem_we), 64'd1);
    chk("sw be", 64'(dmem_be), 64'hF);
    chk("sw wdata", 64'(dmem_wdata), 64'hDEADBEEF);
    chk("sw addr", 64'(dmem_addr), 64'h100);
    chk("sw stall", 64'(stall), 64'd0);
    tick;
    chk("sw wb", 64'(mem_wb_reg), 64'({5'd0, 1'b0, 32'h100}));

    do_load("lb", pk(5'd7, 1'b1, ctl(1, 0, 2'b00, 0, 2'b01), 32'h103, 32'h0, 32'h0),
            32'h80123456, 3, 32'h100, {5'd7, 1'b1, 32'hFFFFFF80});
    do_load("lbu", pk(5'd7, 1'b1, ctl(1, 0, 2'b00, 1, 2'b01), 32'h103, 32'h0, 32'h0),
            32'h80123456, 3, 32'h100, {5'd7, 1'b1, 32'h00000080});
    do_load("lh", pk(5'd8, 1'b1, ctl(1, 0, 2'b01, 0, 2'b01), 32'h102, 32'h0, 32'h0),
            32'h80011234, 0, 32'h100, {5'd8, 1'b1, 32'hFFFF8001});
    do_load("lw", pk(5'd10, 1'b1, ctl(1, 0, 2'b10, 0, 2'b01), 32'h104, 32'h0, 32'h0),
            32'hCAFEF00D, 1, 32'h104, {5'd10, 1'b1, 32'hCAFEF00D});

    drive(pk(5'd3, 1'b1, ctl(1, 0, 2'b01, 0, 2'b01), 32'h101, 32'h0, 32'h0), 1'b0, 32'h0);
    chk("mis req", 64'(dmem_req), 64'd0);
    chk("mis stall", 64'(stall), 64'd0);
    tick;
    chk("mis pulse", 64'(misaligned), 64'd1);
    chk("mis write_en", 64'(mem_wb_reg[32]), 64'd0);
    drive(pk(5'd1, 1'b1, ctl(0, 0, 2'b10, 0, 2'b00), 32'h55, 32'h0, 32'h0), 1'b0, 32'h0);
    tick;
    chk("mis pulse end", 64'(misaligned), 64'd0);
    chk("after mis wb", 64'(mem_wb_reg), 64'({5'd1, 1'b1, 32'h55}));

    drive(pk(5'd0, 1'b0, ctl(0, 1, 2'b10, 0, 2'b00), 32'h102, 32'h1, 32'h0), 1'b1, 32'h0);
    chk("sw mis req", 64'(dmem_req), 64'd0);
    tick;
    chk("sw mis pulse", 64'(misaligned), 64'd1);

    drive(pk(5'd2, 1'b0, ctl(0, 1, 2'b01, 0, 2'b00), 32'h102, 32'h0000ABCD, 32'h0), 1'b1, 32'h0);
    chk("sh be", 64'(dmem_be), 64'hC);
    chk("sh wdata", 64'(dmem_wdata), 64'hABCDABCD);
    chk("sh addr", 64'(dmem_addr), 64'h100);
    tick;
    chk("sh wb", 64'(mem_wb_reg), 64'({5'd2, 1'b0, 32'h102}));
    drive(pk(5'd0, 1'b0, ctl(0, 1, 2'b00, 0, 2'b00), 32'h101, 32'h1234565A, 32'h0), 1'b1, 32'h0);
    chk("sb be", 64'(dmem_be), 64'h2);
    chk("sb wdata", 64'(dmem_wdata), 64'h5A5A5A5A);
    tick;

    drive(pk(5'd31, 1'b1, ctl(0, 0, 2'b10, 0, 2'b10), 32'h999, 32'h0, 32'h400), 1'b1, 32'h0);
    chk("pc req", 64'(dmem_req), 64'd0);
    chk("pc stall", 64'(stall), 64'd0);
    tick;
    chk("pc wb", 64'(mem_wb_reg), 64'({5'd31, 1'b1, 32'h400}));

    drive(pk(5'd9, 1'b1, ctl(1, 0, 2'b10, 0, 2'b01), 32'h200, 32'h0, 32'h0), 1'b0, 32'h0);
    chk("rw stall", 64'(stall), 64'd1);
    tick;
    @(negedge clk);
    rst         = 1'b1;
    exc_mem_reg = '0;
    #1;
    chk("rw held req", 64'(dmem_req), 64'd1);
    chk("rw held addr", 64'(dmem_addr), 64'h200);
    tick;
    chk("rw req", 64'(dmem_req), 64'd0);
    chk("rw stall off", 64'(stall), 64'd0);
    chk("rw wb", 64'(mem_wb_reg), 64'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      drive(pk(5'd4, 1'b1, ctl(1, 0, 2'b10, 0, 2'b01), 32'h300, 32'h0, 32'h0), 1'b0, 32'h0);
      chk("to stall", 64'(stall), 64'd1);
      tick;
    end
    drive(pk(5'd4, 1'b1, ctl(1, 0, 2'b10, 0, 2'b01), 32'h300, 32'h0, 32'h0), 1'b0, 32'h0);
    chk("to release", 64'(stall), 64'd0);
    tick;
    chk("to err", 64'(timeout_err), 64'd1);
    chk("to wb", 64'(mem_wb_reg), 64'd0);
    drive('0, 1'b0, 32'h0);
    tick;
    chk("to sticky", 64'(timeout_err), 64'd1);
    chk("to idle req", 64'(dmem_req), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
